// File: rtl/johnson_phase_decoder_if.sv
// Bus between a Johnson counter stage and its phase decoder.
// master drives samples and control; slave returns the decoded phase.
interface johnson_phase_decoder_if #(
   parameter int WIDTH = 4,
   parameter int IDXW  = $clog2(2*WIDTH)
);
   logic [WIDTH-1:0]   q_in;
   logic               en;
   logic               clr;
   logic [2*WIDTH-1:0] phase_oh;
   logic [IDXW-1:0]    phase_idx;
   logic               valid;
   logic               illegal;
   logic               step_err;
   logic               wrap;
   logic               fault;
   logic [15:0]        wrap_count;

   modport master (
      output q_in, en, clr,
      input  phase_oh, phase_idx, valid,
      input  illegal, step_err, wrap,
      input  fault, wrap_count
   );

   modport slave (
      input  q_in, en, clr,
      output phase_oh, phase_idx, valid,
      output illegal, step_err, wrap,
      output fault, wrap_count
   );
endinterface

// File: rtl/johnson_phase_decoder.sv
// Johnson code checker/decoder: one-hot and binary phase, step and wrap checks.
// Define JPD_WRAP_COUNT_EN to build the saturating wrap counter.
module johnson_phase_decoder #(
   parameter int WIDTH = 4,
   parameter int IDXW  = $clog2(2*WIDTH)
) (
   input logic clk,
   input logic rst,
   johnson_phase_decoder_if.slave bus
);
   localparam int N = 2*WIDTH;
   localparam logic [IDXW-1:0] LAST = IDXW'(N-1);
   localparam logic [1:0] SYNC  = 2'd0;
   localparam logic [1:0] TRACK = 2'd1;
   localparam logic [1:0] FAULT = 2'd2;

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [IDXW-1:0] idx;
   logic [IDXW-1:0] code_idx;
   logic [IDXW-1:0] nxt_idx;
   logic [N-1:0]    oh;
   logic            vld;
   logic            ill;
   logic            serr;
   logic            wrp;
   logic            flt;
   logic            legal;
   logic            take;
   logic            ill_ev;
   logic            serr_ev;
   logic            wrap_ev;
   logic            tracking;

   function automatic logic [WIDTH-1:0] jcode(input int k);
      logic [WIDTH-1:0] ones;
      ones = '1;
      if (k < WIDTH) return ~(ones << k);
      return ones << (k - WIDTH);
   endfunction

   always_comb begin
      legal    = 1'b0;
      code_idx = '0;
      for (int k = 0; k < N; k++) begin
         if (bus.q_in == jcode(k)) begin
            legal    = 1'b1;
            code_idx = IDXW'(k);
         end
      end
   end

   always_comb begin
      tracking = (state == TRACK);
      nxt_idx  = (idx == LAST) ? '0 : idx + 1'b1;
      ill_ev   = bus.en && !legal;
      take     = bus.en && legal &&
                 (!tracking || code_idx != idx);
      // a jump other than +1 while tracking is a resync
      serr_ev  = bus.en && legal && tracking &&
                 code_idx != idx &&
                 code_idx != nxt_idx;
      wrap_ev  = bus.en && legal && tracking &&
                 code_idx == nxt_idx && idx == LAST;
   end

   always_comb begin
      state_nxt = state;
      unique case (1'b1)
         !bus.en:
            state_nxt = state;
         bus.en && !legal:
            state_nxt = (state == SYNC) ? SYNC : FAULT;
         bus.en && legal:
            state_nxt = TRACK;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= SYNC;
         idx   <= '0;
         oh    <= '0;
         vld   <= 1'b0;
         ill   <= 1'b0;
         serr  <= 1'b0;
         wrp   <= 1'b0;
         flt   <= 1'b0;
      end else begin
         state <= state_nxt;
         ill   <= ill_ev;
         serr  <= serr_ev;
         wrp   <= wrap_ev;
         if (ill_ev || serr_ev) flt <= 1'b1;
         else if (bus.clr)      flt <= 1'b0;
         if (ill_ev) begin
            vld <= 1'b0;
         end else if (take) begin
            vld <= 1'b1;
            idx <= code_idx;
            oh  <= {{(N-1){1'b0}}, 1'b1} << code_idx;
         end
      end
   end

`ifdef JPD_WRAP_COUNT_EN
   logic [15:0] wcnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt <= '0;
      end else if (bus.clr) begin
         wcnt <= wrap_ev ? 16'd1 : 16'd0;
      end else if (wrap_ev && wcnt != 16'hFFFF) begin
         wcnt <= wcnt + 16'd1;
      end
   end

   assign bus.wrap_count = wcnt;
`else
   assign bus.wrap_count = 16'h0000;
`endif

   assign bus.phase_oh  = oh;
   assign bus.phase_idx = idx;
   assign bus.valid     = vld;
   assign bus.illegal   = ill;
   assign bus.step_err  = serr;
   assign bus.wrap      = wrp;
   assign bus.fault     = flt;
endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
Downstream consumer of the 4-bit Johnson counter stage. Samples the counter's q bus and checks that it holds a legal Johnson code. Decodes each legal code into a one-hot phase and a binary phase index, and checks the step sequence. Flags illegal codes and skipped steps, and signals each completed 2*WIDTH-state cycle to downstream timing logic.

Parameters:
WIDTH, 4, Johnson counter stage count; sequence length is 2*WIDTH states.
IDXW, $clog2(2*WIDTH) = 3, width of the binary phase index.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
q_in  input  WIDTH  Johnson counter output bus
en  input  1  sample strobe; q_in is evaluated only when en=1
clr  input  1  synchronous clear of the sticky flags and counters
phase_oh  output  2*WIDTH  one-hot decoded phase
phase_idx  output  IDXW  binary decoded phase
valid  output  1  phase outputs hold a tracked legal phase
illegal  output  1  one-cycle pulse: sampled code is not a legal Johnson code
step_err  output  1  one-cycle pulse: legal code but not prev or prev+1
wrap  output  1  one-cycle pulse: phase advanced from 2*WIDTH-1 to 0
fault  output  1  sticky: any illegal or step_err since the last clr or reset
wrap_count  output  16  completed cycles (see Optional Feature)

Behaviour:
- Legal code map, for k = 0..2W-1:
  - k < W: bits [k-1:0] are 1, all others 0.
  - k >= W: bits [W-1:k-W] are 1, all others 0.
  - For W=4: 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7. Every other code is illegal.
- Reset (rst=0, asynchronous):
  - State = SYNC.
  - phase_oh=0, phase_idx=0, valid=0.
  - illegal, step_err, wrap, fault = 0; wrap_count=0.
- Latency: all outputs are registered. A sample taken at edge N appears after edge N (1 cycle).
- With en=0:
  - State, phase and counters hold.
  - illegal, step_err and wrap are 0.
- State machine (state changes only when en=1):
  - SYNC:
    - Legal code: capture the index, set valid=1, go to TRACK. No step check and no wrap.
    - Illegal code: pulse illegal, set fault, stay in SYNC.
  - TRACK, with prev = last captured index:
    - idx == prev: hold (stalled counter), no pulse.
    - idx == prev+1 (mod 2W): capture the index. If prev == 2W-1 and idx == 0, pulse wrap.
    - Any other legal idx: capture it (resync), pulse step_err, set fault, stay in TRACK, no wrap.
    - Illegal code: pulse illegal, set fault, set valid=0, go to FAULT. phase_oh and phase_idx hold the last legal value.
  - FAULT:
    - Legal code: capture it, set valid=1, go to TRACK. No step check.
    - Illegal code: pulse illegal, stay in FAULT.
- phase_oh = 1 << phase_idx whenever valid=1. While valid=0 it holds its last value, or 0 after reset.
- clr=1:
  - Next edge clears fault and wrap_count.
  - Does not change state or phase.
  - If clr coincides with a new error or wrap event, the event wins: fault=1, and wrap_count = 1 if a wrap occurred.
- Counter width rule: wrap_count saturates at 16'hFFFF and does not roll over.
- rst asserted mid-sequence: immediate return to the reset values. The first legal sample after release is accepted from SYNC.

Optional Feature:
JPD_WRAP_COUNT_EN
- Defined: wrap_count increments by 1 on every wrap pulse, saturates at 16'hFFFF, is cleared by clr and by reset.
- Undefined: wrap_count is tied to 16'h0000, no counter flops are built, and the wrap pulse is unaffected.

Test Plan:
- Reset, then en=1 with the free-running sequence 0000,0001,…,1000,0000 -> valid=1 one cycle after the first sample; phase_idx 0..7 then 0; wrap=1 exactly on the 1000->0000 step; step_err=0; fault=0.
- Drive 0101 while in TRACK at idx 3 -> illegal pulse, valid=0, fault=1, phase_idx holds 3; next sample 0111 -> valid=1, idx 3, back in TRACK.
- In TRACK at idx 1 (0001), drive 1111 -> step_err pulse, idx=4, fault=1, no wrap; clr=1 for one cycle -> fault=0.
- Hold q_in=0011 for 5 enabled samples, then en=0 for 3 cycles while q_in changes -> idx stays 2, no pulses.
- With JPD_WRAP_COUNT_EN: run 3 full cycles -> wrap_count=3. Assert rst=0 asynchronously mid-cycle -> wrap_count=0, valid=0 with no clock edge.
- With JPD_WRAP_COUNT_EN: clr and wrap in the same cycle -> wrap_count=1. Without the macro: same run -> wrap_count stays 0.
